fifo_uart_tx: RTL



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_cnt.sv | 36 +++
 rtl/fifo_uart_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// UART_TX_PARITY_EN selects even parity (8E1) instead of 8N1.
package uart_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned CLK_DIV_DEFAULT = 434;

  // PAR is only ever entered when parity is compiled in.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StLoad  = 3'd2,
    StStart = 3'd3,
    StData  = 3'd4,
    StPar   = 3'd5,
    StStop  = 3'd6
  } uart_state_e;

  typedef enum logic {
    ParityNone = 1'b0,
    ParityEven = 1'b1
  } parity_e;

`ifdef UART_TX_PARITY_EN
  localparam parity_e PARITY_TYPE = ParityEven;
`else
  localparam parity_e PARITY_TYPE = ParityNone;
`endif

  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: ticks on the last cycle of each CLK_DIV-cycle period.
// A synchronous clear restarts the period (used on every FSM state entry).
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LastCnt = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LastCnt);

  // Wrapping on tick lets consecutive bits within one state share the counter.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drain stage: pops bytes from the upstream FIFO and shifts them out as UART frames.
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        left_sig,
  input  logic [DATA_W-1:0] FIFO_read_data,
  output logic              read_req,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] DepthW = 3'(DEPTH);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              tick;
  logic              cnt_clr;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif

    unique case (state_q)
      StIdle: begin
        // left_sig is only looked at here, so FIFO activity mid-frame is ignored.
        if (left_sig < DepthW) begin
          state_d = StReq;
        end
      end
      StReq: begin
        state_d = StLoad;
      end
      StLoad: begin
        state_d   = StStart;
        shift_d   = FIFO_read_data;
        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
        par_d     = even_parity(FIFO_read_data);
`endif
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StPar;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StPar: begin
        if (tick) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cnt_clr = (state_d != state_q);

  // tx is computed from next-state values so the pin is a plain flop output.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StPar:   tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign tx         = tx_q;
  assign read_req   = (state_q == StReq);
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StStop) && tick;

endmodule
